// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   rx_state_t           - receiver FSM state encoding
//   DEFAULT_CLKS_PER_BIT - clk cycles per bit (9600 baud at 100 MHz)
//   UART_DATA_BITS       - data bits per 8N1 frame
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 10416;
  localparam int UART_DATA_BITS       = 8;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous pin input.
//   clk       - destination clock
//   reset     - asynchronous, active-high; both flops load RESET_VAL
//   d         - asynchronous input
//   q         - synchronized output (two clk cycles of latency)
// RESET_VAL defaults to 1 so idle-high serial lines come out of reset idle.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first.
//   clk       - system clock
//   reset     - asynchronous, active-high; aborts any frame in progress
//   rx        - serial line, asynchronous, idle high
//   rx_data   - last correctly framed byte, held until the next good frame
//   rx_valid  - one-cycle pulse when rx_data updates
//   frame_err - one-cycle pulse when the stop bit samples low
//   busy      - high while a frame is being received
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronized line
// START | counting to mid start bit; high there means a glitch
// DATA  | sampling DATA_BITS bits at mid-bit, shifting in LSB first
// STOP  | sampling the stop bit, then strobe rx_valid or frame_err
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_TC  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_TC   = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_IDX = 3'(DATA_BITS - 1);

  logic rx_sync;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_sync)
  );

  rx_state_t            state_q,   state_d;
  logic [CW-1:0]        count_q,   count_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic [DATA_BITS-1:0] data_q,    data_d;
  logic                 valid_q,   valid_d;
  logic                 ferr_q,    ferr_d;
  logic                 rx_prev_q, rx_prev_d;
  logic [1:0]           warm_q,    warm_d;
  logic                 line_ok_q, line_ok_d;
  logic                 fall;

  // The synchronizer resets to 1, so a line held low through reset would
  // otherwise look like a falling edge. warm_q marks when rx_sync carries a
  // real pin sample; line_ok_q then requires the line to be seen high once.
  assign fall = line_ok_q & rx_prev_q & ~rx_sync;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    rx_prev_d = rx_sync;
    warm_d    = {warm_q[0], 1'b1};
    line_ok_d = line_ok_q | (warm_q[1] & rx_sync);

    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (count_q == HALF_TC) begin
          count_d = '0;
          if (!rx_sync) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      DATA: begin
        if (count_q == BIT_TC) begin
          count_d = '0;
          shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == LAST_IDX) state_d = STOP;
          else                       bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      STOP: begin
        if (count_q == BIT_TC) begin
          count_d = '0;
          state_d = IDLE;
          if (rx_sync) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      rx_prev_q <= 1'b1;
      warm_q    <= '0;
      line_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      rx_prev_q <= rx_prev_d;
      warm_q    <= warm_d;
      line_ok_q <= line_ok_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx.
// Instance a runs at 16 clk per bit. Instance b runs at 200 clk per bit so
// the +/-3% sender skew case (194 / 206) stays short.
module tb_uart_rx;

  localparam int CPB_A = 16;
  localparam int CPB_B = 200;
  // falling-edge detect latency (2) + half bit + 9 bits + strobe register
  localparam int STROBE_LAT_A = 2 + CPB_A / 2 + 9 * CPB_A + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_a = 1'b0;
  logic       rx_b = 1'b1;
  logic [7:0] rx_data_a, rx_data_b;
  logic       rx_valid_a, rx_valid_b;
  logic       frame_err_a, frame_err_b;
  logic       busy_a, busy_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int   valid_cnt_a = 0, ferr_cnt_a = 0, busy_cyc_a = 0;
  int   last_valid_cyc_a = -1, last_ferr_cyc_a = -1;
  int   busy_rise_cyc_a = -1, busy_fall_cyc_a = -1;
  int   both_cnt = 0, long_cnt = 0;
  logic [7:0] last_data_a = 8'h00;
  logic valid_prev_a = 1'b0, ferr_prev_a = 1'b0, busy_prev_a = 1'b0;
  int   valid_cnt_b = 0, ferr_cnt_b = 0;
  logic [7:0] last_data_b = 8'h00;

  uart_rx #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(8)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx_a),
    .rx_data   (rx_data_a),
    .rx_valid  (rx_valid_a),
    .frame_err (frame_err_a),
    .busy      (busy_a)
  );

  uart_rx #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(8)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx_b),
    .rx_data   (rx_data_b),
    .rx_valid  (rx_valid_b),
    .frame_err (frame_err_b),
    .busy      (busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observation at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rx_valid_a) begin
      valid_cnt_a++;
      last_data_a      = rx_data_a;
      last_valid_cyc_a = cyc;
    end
    if (frame_err_a) begin
      ferr_cnt_a++;
      last_ferr_cyc_a = cyc;
    end
    if (rx_valid_a && frame_err_a) both_cnt++;
    if ((rx_valid_a && valid_prev_a) || (frame_err_a && ferr_prev_a)) long_cnt++;
    if (busy_a) busy_cyc_a++;
    if (busy_a && !busy_prev_a) busy_rise_cyc_a = cyc;
    if (!busy_a && busy_prev_a) busy_fall_cyc_a = cyc;
    valid_prev_a = rx_valid_a;
    ferr_prev_a  = frame_err_a;
    busy_prev_a  = busy_a;
    if (rx_valid_b) begin
      valid_cnt_b++;
      last_data_b = rx_data_b;
    end
    if (frame_err_b) ferr_cnt_b++;
  end

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_b = v;
    else     rx_a = v;
  endtask

  // Called at a negedge; leaves the line at the stop-bit value.
  task automatic send(input bit sel, input logic [7:0] d, input logic stop,
                      input int period, output int start_cyc);
    drive(sel, 1'b0);
    start_cyc = cyc;
    repeat (period) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      repeat (period) @(negedge clk);
    end
    drive(sel, stop);
    repeat (period) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (rx_data_a !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", rx_data_a); end
    checks++;
    if ({rx_valid_a, frame_err_a, busy_a} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp 000", {rx_valid_a, frame_err_a, busy_a});
    end
    // rx_a is low across reset release: this must not start a frame.
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL low_at_release_busy got %b exp 0", busy_a); end
    rx_a = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || valid_cnt_a != 0 || ferr_cnt_a != 0) begin
      errors++; $display("FAIL low_at_release_strobes got busy=%b v=%0d fe=%0d exp 0/0/0",
                         busy_a, valid_cnt_a, ferr_cnt_a);
    end
  endtask

  task automatic test_basic_a5;
    int s, v0, f0;
    v0 = valid_cnt_a; f0 = ferr_cnt_a;
    send(1'b0, 8'hA5, 1'b1, CPB_A, s);
    rx_a = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (rx_data_a !== 8'hA5) begin errors++; $display("FAIL a5_data got %h exp a5", rx_data_a); end
    checks++;
    if (valid_cnt_a - v0 != 1) begin errors++; $display("FAIL a5_valid_count got %0d exp 1", valid_cnt_a - v0); end
    checks++;
    if (last_valid_cyc_a != s + STROBE_LAT_A) begin
      errors++; $display("FAIL a5_valid_time got %0d exp %0d", last_valid_cyc_a, s + STROBE_LAT_A);
    end
    checks++;
    if (ferr_cnt_a != f0) begin errors++; $display("FAIL a5_ferr got %0d exp %0d", ferr_cnt_a, f0); end
    checks++;
    if (busy_rise_cyc_a != s + 3) begin
      errors++; $display("FAIL a5_busy_rise got %0d exp %0d", busy_rise_cyc_a, s + 3);
    end
    checks++;
    if (busy_fall_cyc_a != s + STROBE_LAT_A) begin
      errors++; $display("FAIL a5_busy_fall got %0d exp %0d", busy_fall_cyc_a, s + STROBE_LAT_A);
    end
  endtask

  task automatic test_back_to_back;
    int s, v0;
    v0 = valid_cnt_a;
    send(1'b0, 8'h00, 1'b1, CPB_A, s);
    checks++;
    if (valid_cnt_a - v0 != 1 || last_data_a !== 8'h00) begin
      errors++; $display("FAIL b2b_first got n=%0d d=%h exp n=1 d=00", valid_cnt_a - v0, last_data_a);
    end
    send(1'b0, 8'hFF, 1'b1, CPB_A, s);
    rx_a = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (valid_cnt_a - v0 != 2 || last_data_a !== 8'hFF) begin
      errors++; $display("FAIL b2b_second got n=%0d d=%h exp n=2 d=ff", valid_cnt_a - v0, last_data_a);
    end
  endtask

  task automatic test_glitch;
    int s, v0, f0, b0;
    v0 = valid_cnt_a; f0 = ferr_cnt_a; b0 = busy_cyc_a;
    rx_a = 1'b0;
    repeat (5) @(negedge clk);
    rx_a = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (busy_cyc_a - b0 != CPB_A / 2) begin
      errors++; $display("FAIL glitch_busy_cycles got %0d exp %0d", busy_cyc_a - b0, CPB_A / 2);
    end
    checks++;
    if (valid_cnt_a != v0 || ferr_cnt_a != f0) begin
      errors++; $display("FAIL glitch_strobes got v=%0d fe=%0d exp v=%0d fe=%0d", valid_cnt_a, ferr_cnt_a, v0, f0);
    end
    send(1'b0, 8'h3C, 1'b1, CPB_A, s);
    rx_a = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (rx_data_a !== 8'h3C || valid_cnt_a - v0 != 1) begin
      errors++; $display("FAIL glitch_then_3c got d=%h n=%0d exp d=3c n=1", rx_data_a, valid_cnt_a - v0);
    end
  endtask

  task automatic test_frame_err;
    int s, v0, f0, rise0;
    v0 = valid_cnt_a; f0 = ferr_cnt_a;
    send(1'b0, 8'h5A, 1'b0, CPB_A, s);
    rise0 = busy_rise_cyc_a;
    repeat (40) @(negedge clk);
    checks++;
    if (ferr_cnt_a - f0 != 1) begin errors++; $display("FAIL ferr_count got %0d exp 1", ferr_cnt_a - f0); end
    checks++;
    if (last_ferr_cyc_a != s + STROBE_LAT_A) begin
      errors++; $display("FAIL ferr_time got %0d exp %0d", last_ferr_cyc_a, s + STROBE_LAT_A);
    end
    checks++;
    if (valid_cnt_a != v0) begin errors++; $display("FAIL ferr_no_valid got %0d exp %0d", valid_cnt_a, v0); end
    checks++;
    if (rx_data_a !== 8'h3C) begin errors++; $display("FAIL ferr_data_held got %h exp 3c", rx_data_a); end
    checks++;
    if (busy_a !== 1'b0 || busy_rise_cyc_a != rise0) begin
      errors++; $display("FAIL break_no_restart got busy=%b rise=%0d exp busy=0 rise=%0d", busy_a, busy_rise_cyc_a, rise0);
    end
    rx_a = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int s, v0;
    logic [7:0] d;
    d = 8'hF0;
    rx_a = 1'b0;
    repeat (CPB_A) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rx_a = d[i];
      repeat (CPB_A) @(negedge clk);
    end
    // now inside bit 5 of the frame; bits 0..4 were shifted in
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL mid_frame_busy got %b exp 1", busy_a); end
    reset = 1'b1;
    #1;
    checks++;
    if ({rx_data_a, rx_valid_a, frame_err_a, busy_a} !== 11'h000) begin
      errors++; $display("FAIL reset_mid_outputs got d=%h v=%b fe=%b busy=%b exp all 0",
                         rx_data_a, rx_valid_a, frame_err_a, busy_a);
    end
    rx_a = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    v0 = valid_cnt_a;
    send(1'b0, 8'h81, 1'b1, CPB_A, s);
    rx_a = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (rx_data_a !== 8'h81 || valid_cnt_a - v0 != 1) begin
      errors++; $display("FAIL after_reset_81 got d=%h n=%0d exp d=81 n=1", rx_data_a, valid_cnt_a - v0);
    end
  endtask

  task automatic test_baud_skew;
    int s, v0, f0;
    v0 = valid_cnt_b; f0 = ferr_cnt_b;
    send(1'b1, 8'hC3, 1'b1, CPB_B + CPB_B * 3 / 100, s);
    rx_b = 1'b1;
    repeat (CPB_B) @(negedge clk);
    checks++;
    if (last_data_b !== 8'hC3 || valid_cnt_b - v0 != 1 || ferr_cnt_b != f0) begin
      errors++; $display("FAIL skew_slow got d=%h n=%0d fe=%0d exp d=c3 n=1 fe=0",
                         last_data_b, valid_cnt_b - v0, ferr_cnt_b - f0);
    end
    last_data_b = 8'h00;
    send(1'b1, 8'hC3, 1'b1, CPB_B - CPB_B * 3 / 100, s);
    rx_b = 1'b1;
    repeat (CPB_B) @(negedge clk);
    checks++;
    if (last_data_b !== 8'hC3 || valid_cnt_b - v0 != 2 || ferr_cnt_b != f0) begin
      errors++; $display("FAIL skew_fast got d=%h n=%0d fe=%0d exp d=c3 n=2 fe=0",
                         last_data_b, valid_cnt_b - v0, ferr_cnt_b - f0);
    end
  endtask

  task automatic test_strobe_shape;
    checks++;
    if (both_cnt != 0) begin errors++; $display("FAIL strobes_overlap got %0d exp 0", both_cnt); end
    checks++;
    if (long_cnt != 0) begin errors++; $display("FAIL strobe_width got %0d long pulses exp 0", long_cnt); end
  endtask

  initial begin
    test_reset;
    test_basic_a5;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_reset_mid;
    test_baud_skew;
    test_strobe_shape;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
